// File: rtl/verdict_pkg.sv
// Shared types for the verdict serializer: link geometry, FSM states,
// the buffered snapshot layout and the mask-walking helper.
package verdict_pkg;

    localparam int TS_WIDTH    = 48;
    localparam int LINK_WIDTH  = 64;
    localparam int MASK_WIDTH  = 16;
    localparam int MAX_OUTPUTS = 16;

    // One extra bit so the helper can report "no further set bit".
    localparam int                   IDX_WIDTH = 5;
    localparam logic [IDX_WIDTH-1:0] IDX_NONE  = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        VALUES
    } state_e;

    typedef struct packed {
        logic [TS_WIDTH-1:0]                          ts;
        logic [MASK_WIDTH-1:0]                        mask;
        logic [MAX_OUTPUTS-1:0][LINK_WIDTH-1:0]       values;
    } snapshot_t;

    // Lowest set bit of mask whose index is >= from, or IDX_NONE.
    function automatic logic [IDX_WIDTH-1:0] next_set_bit(
        input logic [MASK_WIDTH-1:0] mask,
        input logic [IDX_WIDTH-1:0]  from
    );
        logic [IDX_WIDTH-1:0] r;
        r = IDX_NONE;
        for (int i = MASK_WIDTH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                r = IDX_WIDTH'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/verdict_serializer_snapshot_fifo.sv
// Single-clock snapshot FIFO; a push into a full FIFO is taken only when
// the same edge pops, so a full queue still sustains one write per cycle.
module snapshot_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/verdict_serializer.sv
// Timestamps active monitor-output cycles, buffers them and streams each
// snapshot as a header word plus one sign-extended word per active output.
module verdict_serializer #(
    parameter int NUM_OUTPUTS = 10,
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH       = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
    input  logic [NUM_OUTPUTS-1:0]            out_aktv,
    output logic [63:0]                       m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              m_last,
    output logic                              overflow,
    output logic [15:0]                       drop_count
);

    import verdict_pkg::*;

    // Entries hold the raw outputs; sign extension happens on the way out.
    localparam int FIFO_W = TS_WIDTH + NUM_OUTPUTS + NUM_OUTPUTS * DATA_WIDTH;

    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    state_e                state_q, state_d;
    snapshot_t             shadow_q, shadow_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [LINK_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           drop_count_q, drop_count_d;

    logic                  capture, drop;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_W-1:0]     fifo_wr_data, fifo_rd_data;
    snapshot_t             fifo_snap;
    logic signed [DATA_WIDTH-1:0] raw;
    logic [IDX_WIDTH-1:0]  step_idx;

    snapshot_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        ts_d         = en ? ts_q + 1'b1 : ts_q;
        capture      = en && (|out_aktv);
        fifo_push    = capture && (!fifo_full || fifo_pop);
        drop         = capture && !fifo_push;
        fifo_wr_data = {ts_q, out_aktv, out_data};
        overflow_d   = overflow_q || drop;
        drop_count_d = (drop && (drop_count_q != 16'hFFFF)) ? drop_count_q + 16'd1
                                                             : drop_count_q;
    end

    always_comb begin
        raw            = '0;
        fifo_snap      = '0;
        fifo_snap.ts   = fifo_rd_data[FIFO_W-1 -: TS_WIDTH];
        fifo_snap.mask = MASK_WIDTH'(fifo_rd_data[NUM_OUTPUTS*DATA_WIDTH +: NUM_OUTPUTS]);
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            raw                 = fifo_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
            fifo_snap.values[k] = LINK_WIDTH'(raw);
        end
    end

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        fifo_pop  = 1'b0;
        step_idx  = IDX_NONE;
        unique case (state_q)
            IDLE: begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shadow_d  = fifo_snap;
                    m_data_d  = {fifo_snap.ts, fifo_snap.mask};
                    m_valid_d = 1'b1;
                    state_d   = HEADER;
                end
            end
            HEADER: begin
                if (m_ready) begin
                    step_idx = next_set_bit(shadow_q.mask, '0);
                    idx_d    = step_idx;
                    m_data_d = shadow_q.values[step_idx[IDX_WIDTH-2:0]];
                    m_last_d = (next_set_bit(shadow_q.mask, step_idx + 5'd1) == IDX_NONE);
                    state_d  = VALUES;
                end
            end
            VALUES: begin
                if (m_ready) begin
                    if (m_last_q) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        step_idx = next_set_bit(shadow_q.mask, idx_q + 5'd1);
                        idx_d    = step_idx;
                        m_data_d = shadow_q.values[step_idx[IDX_WIDTH-2:0]];
                        m_last_d = (next_set_bit(shadow_q.mask, step_idx + 5'd1) == IDX_NONE);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q         <= '0;
            state_q      <= IDLE;
            shadow_q     <= '0;
            idx_q        <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            ts_q         <= ts_d;
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            idx_q        <= idx_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_verdict_serializer.sv
// Bench for verdict_serializer: directed scenarios then random traffic,
// every cycle compared against a snapshot/packet-level reference model.
module tb_verdict_serializer;

    localparam int N     = 10;
    localparam int DW    = 12;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_aktv;
    logic [63:0]     m_data;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;
    logic            overflow;
    logic [15:0]     drop_count;

    always #5 clk = ~clk;

    verdict_serializer #(
        .NUM_OUTPUTS (N),
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .out_data   (out_data),
        .out_aktv   (out_aktv),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queued packets as flat words plus their lengths,
    // and the words of the packet currently offered to the sink.
    logic [63:0] exp_q[$];
    logic [63:0] fifo_words[$];
    int          fifo_lens[$];
    bit          busy  = 1'b0;
    bit          armed = 1'b0;
    bit          ovf   = 1'b0;
    int          drops = 0;
    logic [47:0] ts_m  = '0;
    logic [63:0] bp_word;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        assert (got === want) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] sext(input logic [DW-1:0] v);
        longint s;
        s = longint'(v);
        if (v >= (1 << (DW - 1))) s = s - (longint'(1) << DW);
        return 64'(s);
    endfunction

    task automatic model_edge();
        int n;
        if (rst) begin
            exp_q.delete();
            fifo_words.delete();
            fifo_lens.delete();
            busy  = 1'b0;
            ovf   = 1'b0;
            drops = 0;
            ts_m  = '0;
            armed = 1'b1;
            return;
        end
        if (busy) begin
            if (m_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) busy = 1'b0;
            end
        end else if (fifo_lens.size() > 0) begin
            n = fifo_lens.pop_front();
            for (int i = 0; i < n; i++) exp_q.push_back(fifo_words.pop_front());
            busy = 1'b1;
        end
        if (en && (out_aktv != '0)) begin
            if (fifo_lens.size() < DEPTH) begin
                fifo_words.push_back({ts_m, 16'(out_aktv)});
                n = 1;
                for (int k = 0; k < N; k++) begin
                    if (out_aktv[k]) begin
                        fifo_words.push_back(sext(out_data[k*DW +: DW]));
                        n++;
                    end
                end
                fifo_lens.push_back(n);
            end else begin
                ovf = 1'b1;
                if (drops < 65535) drops++;
            end
        end
        if (en) ts_m = ts_m + 48'd1;
    endtask

    // Check outputs now (mid-cycle), advance the model, then cross one edge.
    task automatic step();
        if (armed) begin
            chk("m_valid", 64'(m_valid), 64'(busy));
            chk("m_last", 64'(m_last), 64'(busy && (exp_q.size() == 1)));
            if (busy) chk("m_data", m_data, exp_q[0]);
            chk("overflow", 64'(overflow), 64'(ovf));
            chk("drop_count", 64'(drop_count), 64'(drops));
        end
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset held with all outputs active: nothing may be captured.
        rst      = 1'b1;
        en       = 1'b1;
        m_ready  = 1'b1;
        out_aktv = 10'h3FF;
        out_data = (N*DW)'({$urandom, $urandom, $urandom, $urandom});
        repeat (3) step();
        chk("reset_m_data", m_data, 64'h0);
        chk("reset_m_valid", 64'(m_valid), 64'h0);

        // First capture after release carries ts=0.
        rst = 1'b0;
        step();
        out_aktv = '0;
        step();
        chk("first_header", m_data, {48'd0, 16'h03FF});
        repeat (14) step();

        // Single packet at ts=5: out0=1, out2=-3.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        out_data           = '0;
        out_data[0 +: DW]  = 12'd1;
        out_data[24 +: DW] = 12'hFFD;
        out_aktv           = 10'h005;
        step();
        out_aktv = '0;
        step();
        chk("single_hdr", m_data, 64'h0000_0000_0005_0005);
        chk("single_hdr_valid", 64'(m_valid), 64'h1);
        step();
        chk("single_v0", m_data, 64'h1);
        step();
        chk("single_v1", m_data, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("single_last", 64'(m_last), 64'h1);
        repeat (3) step();

        // Backpressure for 10 cycles right after the header handshake.
        out_data = (N*DW)'({$urandom, $urandom, $urandom, $urandom});
        bp_word  = sext(out_data[4*DW +: DW]);
        out_aktv = 10'h0F0;
        step();
        out_aktv = '0;
        repeat (2) step();
        m_ready = 1'b0;
        repeat (10) step();
        chk("bp_hold", m_data, bp_word);
        m_ready = 1'b1;
        repeat (8) step();

        // Overflow: six back-to-back captures against a stalled sink.
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            out_data          = '0;
            out_data[0 +: DW] = DW'(i);
            out_aktv          = 10'h001;
            step();
        end
        out_aktv = '0;
        step();
        chk("ovf_drop_count", 64'(drop_count), 64'd1);
        chk("ovf_flag", 64'(overflow), 64'h1);
        m_ready = 1'b1;
        repeat (20) step();

        // Enable gating: queued packet drains while en=0 blocks captures.
        out_aktv = 10'h002;
        step();
        en       = 1'b0;
        out_aktv = 10'h200;
        repeat (20) step();
        chk("gate_drops", 64'(drop_count), 64'd1);
        en = 1'b1;
        step();
        out_aktv = '0;
        repeat (6) step();

        // Reset after the header handshake of a 3-word packet.
        out_aktv = 10'h003;
        step();
        out_aktv = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("midrst_valid", 64'(m_valid), 64'h0);
        rst = 1'b0;
        repeat (8) step();

        // Random traffic with random sink stalls and rare resets.
        repeat (400) begin
            rst      = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 9) != 0);
            out_aktv = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            out_data = (N*DW)'({$urandom, $urandom, $urandom, $urandom});
            m_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        rst      = 1'b0;
        out_aktv = '0;
        m_ready  = 1'b1;
        repeat (80) step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/verdict_serializer.md
# verdict_serializer

Output-side companion to the Clash-generated `topEntity` monitor. The input side pulses `new_input_k` with a value; this block consumes the monitor's `output_k` / `output_k_aktv` pairs. Every cycle in which at least one output is active becomes a snapshot: the block timestamps it, buffers it in a FIFO, and streams it out as a variable-length packet of 64-bit words over a valid/ready interface. It sits between `topEntity` and the trace/host link, so verdicts produced in bursts are not lost to a slow sink.

## Interface
- `NUM_OUTPUTS`, default 10: monitor output streams; legal range 1..16.
- `DATA_WIDTH`, default 64: width of each monitor output; legal range 1..64; sign-extended to 64 on the link.
- `TS_WIDTH`, default 48: cycle-timestamp width; fixed at 48.
- `DEPTH`, default 8: number of snapshot FIFO entries; must be a power of 2 and ≥2.

Ports:
- `clk`  in  1  clock; rising-edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  enable; shared with `topEntity`.
- `out_data`  in  `NUM_OUTPUTS*DATA_WIDTH`  monitor outputs, packed; output k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; signed.
- `out_aktv`  in  `NUM_OUTPUTS`  per-output activity strobes.
- `m_data`  out  64  packet word.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  sink accepts the word.
- `m_last`  out  1  current word is the last word of its packet.
- `overflow`  out  1  sticky; a snapshot has been dropped since reset.
- `drop_count`  out  16  count of dropped snapshots; saturates at 0xFFFF.

## Operation
- **Timestamp counter `ts`**
  - 48 bits; reset value 0.
  - Increments every cycle with `en`=1; wraps to 0 after 2^48−1.
  - Frozen while `en`=0.
- **Capture**
  - Occurs on a rising edge with `en`=1 and `|out_aktv`=1.
  - Writes {`ts`, `out_aktv`, all `out_data`} into the FIFO.
  - `ts` in the entry is its value before that edge's increment.
  - When `en`=0, `out_aktv` is ignored.
- **FIFO full**
  - A capture is accepted only if the same edge also pops an entry.
  - Otherwise the capture is dropped, `overflow` is set, and `drop_count` increments.
- **Packet format**
  - Header word: {ts[47:0], mask[15:0]}; the mask is `out_aktv` zero-extended to 16 bits.
  - Then one word per set mask bit, in ascending index order; each word is the output value sign-extended to 64 bits.
  - Packet length = 1 + popcount(mask); range 2..NUM_OUTPUTS+1.
- **FSM**
  - `IDLE`: `m_valid`=0. If the FIFO is non-empty, pop into the shadow register and go to `HEADER`.
  - `HEADER`: present the header word. On `m_valid&&m_ready`, set `idx` = lowest set mask bit and go to `VALUES`.
  - `VALUES`: present value[`idx`]; `m_last`=1 when `idx` is the highest set bit. On handshake, either advance `idx` to the next set bit, or, if this is the last word, go to `IDLE`.
- **Handshake rules**
  - While `m_valid`=1 and `m_ready`=0, `m_data`, `m_last` and `m_valid` hold stable.
  - `m_valid` never drops without a handshake, except on reset.
  - `m_last` is 0 whenever `m_valid`=0.
- **Enable**: `en`=0 does not stall draining.
- **Reset mid-operation**: the packet in flight is abandoned and not resumed. The FIFO, shadow register, `ts`, `overflow` and `drop_count` all clear.
- **Reset values**: `m_valid`=0, `m_last`=0, `m_data`=0, `overflow`=0, `drop_count`=0, FSM in `IDLE`.

## Timing
- Capture at edge t, with the FIFO empty and the FSM in `IDLE`: the FIFO is non-empty after t. The FSM pops at edge t+1. The header is visible with `m_valid`=1 after edge t+1.
- Latency from capture to header: 2 edges minimum.
- With `m_ready` held at 1, one word is transferred per cycle.
- After the `m_last` handshake there is one `IDLE` bubble cycle before the next header.
- Snapshots in consecutive cycles are all captured if FIFO space permits. FIFO throughput is 1 write and 1 pop per cycle.
- All outputs are registered; there is no combinational path from `m_ready` to `m_data`.

## Structure
- **Package `verdict_pkg`**:
  - `TS_WIDTH`, `LINK_WIDTH`=64, `MASK_WIDTH`=16.
  - State enum `{IDLE, HEADER, VALUES}`.
  - Snapshot entry struct (ts, mask, values).
  - Helper function `next_set_bit(mask, idx)`.
- **Sub-module `snapshot_fifo`**:
  - Synchronous single-clock FIFO, parameterized width/depth.
  - Outputs `full`/`empty`; push and pop in the same cycle are allowed when full.
- **Top level**: timestamp counter, capture logic, shadow register, FSM, drop accounting.

## Test plan
Defaults: NUM_OUTPUTS=10, DEPTH=8, unless stated.
- **Reset**: hold `rst`=1 for 3 cycles with `out_aktv`=0x3FF → `m_valid`=0, `overflow`=0, `drop_count`=0. After release, the first capture carries `ts`=0.
- **Single packet**: `out_aktv`=0x005 at `ts`=5, out0=1, out2=−3, `m_ready`=1 → words are 0x0000_0000_0005_0005, then 1, then 0xFFFF_FFFF_FFFF_FFFD with `m_last`=1. The header appears 2 edges after capture.
- **Backpressure**: hold `m_ready`=0 for 10 cycles mid-packet → `m_data`, `m_valid`, `m_last` stay unchanged. Release `m_ready` → the remaining words arrive with none lost or duplicated.
- **Overflow**: DEPTH=4, `m_ready`=0, 6 consecutive captures with out0 = 1..6 → `drop_count`=1, `overflow`=1. Drained packets carry 1..5 in order.
- **Enable gating**: `en`=0 for 20 cycles with `out_aktv`=0x200 → no capture and `ts` frozen. A packet already queued drains normally.
- **Reset mid-packet**: assert `rst` after the header handshake of a 3-word packet → `m_valid`=0 on the next cycle, FIFO empty, no residual words after release.
